// File: rtl/bd_pkg.sv
// Shared types and slice-bound helpers for the Gray stream converter.
// Stage records carry control bits; the word travels beside them.
package bd_pkg;

  typedef enum logic {
    BD_DECODE = 1'b0,
    BD_ENCODE = 1'b1
  } bd_mode_e;

  typedef struct packed {
    logic     valid;
    bd_mode_e mode;
    logic     prefix;
  } bd_stage_t;

  function automatic int bd_slice_c(
    input int width,
    input int stages
  );
    return (width + stages - 1) / stages;
  endfunction

  // MSB-first slices; a negative hi marks an empty trailing slice
  function automatic int bd_slice_hi(
    input int width,
    input int stages,
    input int k
  );
    return width - 1 - k * bd_slice_c(width, stages);
  endfunction

  function automatic int bd_slice_lo(
    input int width,
    input int stages,
    input int k
  );
    int lo;
    lo = width - (k + 1) * bd_slice_c(width, stages);
    return (lo < 0) ? 0 : lo;
  endfunction

endpackage

// File: rtl/gray_slice_stage.sv
// One pipeline register resolving a slice of the Gray prefix XOR.
// Stage 0 also applies the binary-to-Gray encode for encode beats.
module gray_slice_stage
  import bd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int IDX    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  bd_stage_t        i_st,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_adv,
  output logic             o_load,
  output bd_stage_t        o_st,
  output logic [WIDTH-1:0] o_word
);

  localparam int HI = bd_slice_hi(WIDTH, STAGES, IDX);
  localparam int LO = bd_slice_lo(WIDTH, STAGES, IDX);

  bd_stage_t        r_st;
  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] w_word;
  logic             w_pfx;

  assign o_load = !r_st.valid || i_adv;
  assign o_st   = r_st;
  assign o_word = r_word;

  always_comb begin
    w_word = i_word;
    w_pfx  = i_st.prefix;
    if (IDX == 0 && i_st.mode == BD_ENCODE) begin
      w_word = i_word ^ (i_word >> 1);
    end else if (i_st.mode == BD_DECODE) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (i <= HI && i >= LO) begin
          w_pfx     = w_pfx ^ i_word[i];
          w_word[i] = w_pfx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st   <= '0;
      r_word <= '0;
    end else if (o_load) begin
      r_st.valid <= i_st.valid;
      if (i_st.valid) begin
        r_st.mode   <= i_st.mode;
        r_st.prefix <= w_pfx;
        r_word      <= w_word;
      end
    end
  end

endmodule

// File: rtl/gray_stream_decoder.sv
// Pipelined Gray<->binary converter with valid/ready streaming.
// WIDTH >= 2, 1 <= STAGES <= WIDTH; out_ready reaches in_ready combinationally.
module gray_stream_decoder
  import bd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic [CNT_W-1:0] beat_count
);

  bd_stage_t        w_st   [STAGES+1];
  logic [WIDTH-1:0] w_word [STAGES+1];
  logic [STAGES-1:0] w_load;
  logic [STAGES-1:0] w_adv;
  logic [CNT_W-1:0] r_beat_count;

  assign w_st[0]   = '{valid: in_valid,
                       mode: bd_mode_e'(in_mode),
                       prefix: 1'b0};
  assign w_word[0] = in_data;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == STAGES - 1) begin : g_last
      assign w_adv[k] = out_ready;
    end else begin : g_mid
      assign w_adv[k] = w_load[k+1];
    end

    gray_slice_stage #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES),
      .IDX    (k)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .i_st   (w_st[k]),
      .i_word (w_word[k]),
      .i_adv  (w_adv[k]),
      .o_load (w_load[k]),
      .o_st   (w_st[k+1]),
      .o_word (w_word[k+1])
    );
  end

  assign in_ready   = rst || w_load[0];
  assign out_valid  = w_st[STAGES].valid;
  assign out_data   = w_word[STAGES];
  assign out_mode   = w_st[STAGES].mode;
  assign beat_count = r_beat_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_count <= '0;
    end else if (out_valid && out_ready) begin
      r_beat_count <= r_beat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_gray_stream_decoder.sv
// Scoreboard bench: 8-bit/2-stage instance for handshake behaviour,
// 13-bit/4-stage/4-bit-counter instance for exhaustive decode and wrap.
module tb_gray_stream_decoder;

  logic clk;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  logic       a_rst, a_in_valid, a_in_ready, a_in_mode;
  logic       a_out_valid, a_out_ready, a_out_mode;
  logic [7:0] a_in_data, a_out_data;
  logic [15:0] a_beat_count;

  logic        b_rst, b_in_valid, b_in_ready, b_in_mode;
  logic        b_out_valid, b_out_ready, b_out_mode;
  logic [12:0] b_in_data, b_out_data;
  logic [3:0]  b_beat_count;

  gray_stream_decoder #(.WIDTH(8), .STAGES(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst(a_rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_mode(a_out_mode),
    .beat_count(a_beat_count)
  );

  gray_stream_decoder #(.WIDTH(13), .STAGES(4), .CNT_W(4)) u_dut13 (
    .clk(clk), .rst(b_rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_mode(b_out_mode),
    .beat_count(b_beat_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: binary is the XOR of every right shift of the Gray word
  function automatic logic [31:0] ref_dec(input logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int s = 0; s < 32; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic logic [31:0] ref_enc(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor for instance A
  logic [31:0] qa_d[$];
  logic        qa_m[$];
  int          a_xfers;
  int          a_first_acc;
  int          a_first_out;
  logic        a_stall;
  logic [7:0]  a_hold_d;
  logic        a_hold_m;

  always @(negedge clk) begin
    if (a_rst) begin
      qa_d.delete();
      qa_m.delete();
      a_xfers     = 0;
      a_first_acc = -1;
      a_first_out = -1;
      a_stall     = 1'b0;
    end else begin
      if (a_stall) begin
        chk("a_stall_valid", 32'(a_out_valid), 32'd1);
        chk("a_stall_data", 32'(a_out_data), 32'(a_hold_d));
        chk("a_stall_mode", 32'(a_out_mode), 32'(a_hold_m));
      end
      if (a_out_valid && a_out_ready) begin
        if (qa_d.size() == 0) begin
          chk("a_spurious_out", 32'(a_out_data), 32'hDEAD_BEEF);
        end else begin
          chk("a_data", 32'(a_out_data), qa_d.pop_front());
          chk("a_mode", 32'(a_out_mode), 32'(qa_m.pop_front()));
        end
        a_xfers++;
        if (a_first_out < 0) a_first_out = cyc;
      end
      a_stall  = a_out_valid && !a_out_ready;
      a_hold_d = a_out_data;
      a_hold_m = a_out_mode;
      if (a_in_valid && a_in_ready) begin
        qa_d.push_back(a_in_mode ? ref_enc(32'(a_in_data))
                                 : ref_dec(32'(a_in_data)));
        qa_m.push_back(a_in_mode);
        if (a_first_acc < 0) a_first_acc = cyc + 1;
      end
    end
  end

  // ---------------- scoreboard / monitor for instance B
  logic [31:0] qb[$];
  int          b_xfers;

  always @(negedge clk) begin
    if (b_rst) begin
      qb.delete();
      b_xfers = 0;
    end else begin
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) begin
          chk("b_spurious_out", 32'(b_out_data), 32'hDEAD_BEEF);
        end else begin
          chk("b_data", 32'(b_out_data), qb.pop_front());
          chk("b_mode", 32'(b_out_mode), 32'd0);
        end
        b_xfers++;
      end
      if (b_in_valid && b_in_ready)
        qb.push_back(b_in_mode ? ref_enc(32'(b_in_data))
                               : ref_dec(32'(b_in_data)));
    end
  end

  // ---------------- drivers
  task automatic a_send(input logic [7:0] d, input logic m);
    int n;
    n = 0;
    a_in_valid = 1'b1;
    a_in_data  = d;
    a_in_mode  = m;
    @(negedge clk);
    while (!a_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!a_in_ready) chk("a_send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
  endtask

  task automatic a_drain();
    int n;
    n = 0;
    a_out_ready = 1'b1;
    while (qa_d.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("a_drain_left", 32'(qa_d.size()), 32'd0);
    @(posedge clk);
    #1;
    chk("a_beat_count", 32'(a_beat_count), 32'(a_xfers & 16'hFFFF));
  endtask

  task automatic b_send(input logic [12:0] d);
    int n;
    n = 0;
    b_in_valid = 1'b1;
    b_in_data  = d;
    b_in_mode  = 1'b0;
    @(negedge clk);
    while (!b_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!b_in_ready) chk("b_send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
  endtask

  task automatic b_drain();
    int n;
    n = 0;
    while (qb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("b_drain_left", 32'(qb.size()), 32'd0);
    @(posedge clk);
    #1;
    chk("b_beat_count", 32'(b_beat_count), 32'(b_xfers & 15));
  endtask

  initial begin
    int acc;
    a_rst = 1'b1; a_in_valid = 1'b0; a_in_data = '0; a_in_mode = 1'b0;
    a_out_ready = 1'b1;
    b_rst = 1'b1; b_in_valid = 1'b0; b_in_data = '0; b_in_mode = 1'b0;
    b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_data", 32'(a_out_data), 32'd0);
    chk("rst_out_mode", 32'(a_out_mode), 32'd0);
    chk("rst_beat_count", 32'(a_beat_count), 32'd0);
    @(posedge clk);
    #1;
    a_rst = 1'b0;
    b_rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(a_in_ready), 32'd1);
    @(posedge clk);
    #1;

    // back-to-back decode, latency and count
    a_send(8'hC0, 1'b0);
    a_send(8'hFF, 1'b0);
    a_send(8'h80, 1'b0);
    a_send(8'h00, 1'b0);
    a_drain();
    chk("latency", 32'(a_first_out - a_first_acc), 32'd1);
    chk("count_after_4", 32'(a_beat_count), 32'd4);

    // alternating modes
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) a_send(8'hAA, 1'b1);
      else            a_send(8'hFF, 1'b0);
    end
    a_drain();

    // stall with a stream pending
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 8'h10;
    a_in_mode   = 1'b0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (a_in_ready) acc++;
      @(posedge clk);
      #1;
      if (a_in_ready) a_in_data = a_in_data + 8'd1;
    end
    @(negedge clk);
    chk("stall_accepts", 32'(acc), 32'd2);
    chk("stall_in_ready", 32'(a_in_ready), 32'd0);
    @(posedge clk);
    #1;
    a_out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      a_in_data = a_in_data + 8'd3;
      a_in_mode = ~a_in_mode;
    end
    a_in_valid = 1'b0;
    a_drain();

    // reset with two beats in flight
    a_out_ready = 1'b0;
    a_send(8'h11, 1'b0);
    a_send(8'h22, 1'b1);
    a_rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(a_out_valid), 32'd0);
    chk("midrst_beat_count", 32'(a_beat_count), 32'd0);
    chk("midrst_in_ready", 32'(a_in_ready), 32'd1);
    @(posedge clk);
    #1;
    a_rst = 1'b0;
    @(negedge clk);
    chk("after_rst_out_valid", 32'(a_out_valid), 32'd0);
    @(posedge clk);
    #1;
    a_out_ready = 1'b1;
    a_send(8'h80, 1'b0);
    a_drain();
    chk("count_after_rst", 32'(a_beat_count), 32'd1);

    // random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      a_in_valid  = ($urandom % 4) != 0;
      a_in_data   = 8'($urandom);
      a_in_mode   = 1'($urandom);
      a_out_ready = ($urandom % 4) != 0;
      @(posedge clk);
      #1;
    end
    a_in_valid = 1'b0;
    a_drain();

    // 4-bit counter wrap on the wide instance
    for (int i = 0; i < 17; i++) b_send(13'(i * 37 + 5));
    b_drain();
    chk("wrap_count", 32'(b_beat_count), 32'd1);

    b_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    b_rst = 1'b0;
    @(posedge clk);
    #1;

    // exhaustive 13-bit decode
    for (int c = 0; c < 8192; c++) b_send(13'(c));
    b_drain();
    chk("exhaustive_xfers", 32'(b_xfers), 32'd8192);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
